id_ex_hazard_ctrl: RTL and testbench
====================================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller driving the enable/flush inputs of the IF/ID, ID/EX and EX/MEM latches.
//  Sits beside the ID/EX latch: consumes ID-stage source registers plus EX/MEM-stage writer info and memory hits.
//  Produces PC write enable, per-latch enable/flush, the halted indication and a stall-cycle counter.
// PARAMETERS
//  CNT_W     32   width of stall_cnt perf counter (saturating)
// PORTS
//  CLK            in   1      system clock, rising edge
//  RST            in   1      synchronous reset, active-high
//  ihit           in   1      instruction fetch completed this cycle
//  dhit           in   1      data access completed this cycle
//  Rs_id, Rt_id   in   5      source regs of instruction in ID (regbits_t)
//  usesRt_id      in   1      ID instruction reads Rt
//  dREN_ex        in   1      EX instruction is a load
//  RegWr_ex       in   1      EX instruction writes a register
//  wsel_ex        in   5      EX destination register
//  RegWr_mem      in   1      MEM instruction writes a register
//  wsel_mem       in   5      MEM destination register
//  dmemReq_mem    in   1      MEM instruction has dREN or dWEN set
//  jumpFlush_ex   in   1      taken branch/jump resolved in EX
//  halt_ex        in   1      halt in EX; halt_mem in 1: halt in MEM
//  pc_en          out  1      PC register write enable
//  ifid_en, ifid_flush  out 1 IF/ID latch enable / flush
//  idex_en, idex_flush  out 1 ID/EX latch enable / flush
//  exmem_en       out  1      EX/MEM latch enable
//  halted         out  1      core halted (sticky until RST)
//  stall_cnt      out  CNT_W  cycles with pc_en=0 while not halted
// BEHAVIOUR
//  FSM haz_state_t: RUN, DWAIT, HALT. Reset: state=RUN, stall_cnt=0, halted=0.
//  Outputs combinational from state+inputs; during RST asserted all enables=0, flushes=0.
//  Priority each cycle in RUN (highest first):
//   1 dmemReq_mem & !dhit: all enables 0, no flush; next=DWAIT.
//   2 halt_mem & !(dmemReq_mem & !dhit): all enables 0; next=HALT.
//   3 jumpFlush_ex | halt_ex: pc_en=1 (jumpFlush) / 0 (halt), ifid_flush=1, idex_flush=1, all latches enabled.
//   4 RAW stall: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (bubble), exmem_en=1.
//   5 !ihit: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
//   6 else all enables 1, flushes 0.
//  DWAIT: hold all enables 0 until dhit; on dhit cycle apply RUN rules 3-6 with rule 1 ignored; next=RUN.
//  HALT: all enables 0, flushes 0, halted=1; absorbing until RST.
//  RAW match(w) = w!=0 & (w==Rs_id | (usesRt_id & w==Rt_id)); writes to $0 never stall.
//  Load-use stall = dREN_ex & RegWr_ex & match(wsel_ex); one bubble, re-evaluated each cycle.
//  stall_cnt increments when pc_en=0 & state!=HALT & !RST; saturates at all-ones, no wrap.
//  Simultaneous jumpFlush_ex and RAW stall: flush wins (stalled ID instruction is squashed).
//  RST mid-DWAIT or mid-HALT: next cycle RUN, counters cleared.
// CONFIGURATION
//  HAZ_FWD_EN defined: forwarding unit present; RAW stall = load-use only.
//  HAZ_FWD_EN undefined: RAW stall also when (RegWr_ex & match(wsel_ex)) | (RegWr_mem & match(wsel_mem));
//   stall persists until producer leaves MEM (up to 2 bubbles).
// STRUCTURE
//  haz_state_t enum (RUN=2'd0, DWAIT=2'd1, HALT=2'd2) added to cpu_types_pkg; reuse regbits_t.
//  One sub-module: haz_raw_cmp (5-bit match(w) comparator, instanced for EX and MEM writers).
// TESTING
//  1 RST=1 2 cycles, release -> pc_en=1, all latches en, halted=0, stall_cnt=0 with ihit=1.
//  2 dREN_ex=1,RegWr_ex=1,wsel_ex=5,Rs_id=5 -> pc_en=0,ifid_en=0,idex_flush=1 one cycle; stall_cnt=1.
//  3 wsel_ex=0,Rs_id=0,dREN_ex=1 -> no stall; no-FWD build with RegWr_mem=1,wsel_mem=8,Rt_id=8,usesRt_id=1 -> stall.
//  4 dmemReq_mem=1,dhit=0 for 3 cycles then dhit=1 -> all enables 0 for 3 cycles, RUN after; stall_cnt=3.
//  5 jumpFlush_ex=1 with load-use match same cycle -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
//  6 halt_mem=1 -> next cycle halted=1, enables 0 held 10 cycles; RST=1 -> RUN, halted=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
//   regbits_t   : 5-bit architectural register index
//   haz_state_t : hazard controller FSM state (RUN / DWAIT / HALT)
//   haz_ctrl_t  : bundle of pipeline-latch control strobes
//   haz_flow    : control word for the non-memory-wait rules
//                 (flush, RAW bubble, fetch miss, free run)
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } haz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
  } haz_ctrl_t;

  localparam haz_ctrl_t HAZ_CTRL_IDLE = '0;

  // Lower-priority rules, shared by RUN and by the dhit cycle of DWAIT.
  // A flush squashes a stalled ID instruction, so it outranks the RAW bubble.
  function automatic haz_ctrl_t haz_flow(input logic jump_flush,
                                         input logic halt_ex,
                                         input logic raw_stall,
                                         input logic ihit);
    haz_ctrl_t c;
    c = '1;
    c.ifid_flush = 1'b0;
    c.idex_flush = 1'b0;
    if (jump_flush || halt_ex) begin
      c.pc_en      = jump_flush;
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (raw_stall || !ihit) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/haz_raw_cmp.sv
// RAW dependency comparator for one register writer.
//   wsel_i    : destination register of the writer
//   rs_i/rt_i : source registers of the instruction in ID
//   uses_rt_i : ID instruction actually reads rt
//   match_o   : writer produces a value the ID instruction reads ($0 never matches)
module haz_raw_cmp (
  input  logic [4:0] wsel_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rt_i,
  output logic       match_o
);

  assign match_o = (wsel_i != '0) &&
                   ((wsel_i == rs_i) || (uses_rt_i && (wsel_i == rt_i)));

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Pipeline hazard/stall controller for the IF/ID, ID/EX and EX/MEM latches.
// Inputs : CLK, RST (sync, active-high), ihit, dhit, Rs_id, Rt_id, usesRt_id,
//          dREN_ex, RegWr_ex, wsel_ex, RegWr_mem, wsel_mem, dmemReq_mem,
//          jumpFlush_ex, halt_ex, halt_mem
// Outputs: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
//          halted (sticky until RST), stall_cnt (saturating stall-cycle count)
// Build option: define HAZ_FWD_EN when a forwarding unit exists; RAW stalls
// then reduce to load-use only. Without it, any in-flight EX/MEM writer of an
// ID source register stalls until it has left MEM.
module id_ex_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       Rs_id,
  input  logic [4:0]       Rt_id,
  input  logic             usesRt_id,
  input  logic             dREN_ex,
  input  logic             RegWr_ex,
  input  logic [4:0]       wsel_ex,
  input  logic             RegWr_mem,
  input  logic [4:0]       wsel_mem,
  input  logic             dmemReq_mem,
  input  logic             jumpFlush_ex,
  input  logic             halt_ex,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  haz_state_t       state_q, state_d;
  haz_ctrl_t        ctrl;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             match_ex;
  logic             raw_stall;
  logic             dmiss;

  haz_raw_cmp u_cmp_ex (
    .wsel_i    (wsel_ex),
    .rs_i      (Rs_id),
    .rt_i      (Rt_id),
    .uses_rt_i (usesRt_id),
    .match_o   (match_ex)
  );

`ifdef HAZ_FWD_EN
  assign raw_stall = dREN_ex && RegWr_ex && match_ex;
`else
  logic match_mem;

  haz_raw_cmp u_cmp_mem (
    .wsel_i    (wsel_mem),
    .rs_i      (Rs_id),
    .rt_i      (Rt_id),
    .uses_rt_i (usesRt_id),
    .match_o   (match_mem)
  );

  // Load-use is a subset of the EX-writer term, so it needs no separate check.
  assign raw_stall = (RegWr_ex && match_ex) || (RegWr_mem && match_mem);
`endif

  assign dmiss = dmemReq_mem && !dhit;

  always_comb begin
    ctrl    = HAZ_CTRL_IDLE;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (dmiss) begin
          state_d = DWAIT;
        end else if (halt_mem) begin
          state_d = HALT;
        end else begin
          ctrl = haz_flow(jumpFlush_ex, halt_ex, raw_stall, ihit);
        end
      end
      DWAIT: begin
        // The completing access is not re-checked for a miss on the dhit cycle.
        if (dhit) begin
          ctrl    = haz_flow(jumpFlush_ex, halt_ex, raw_stall, ihit);
          state_d = RUN;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
    if (RST) begin
      ctrl = HAZ_CTRL_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!ctrl.pc_en && (state_q != HALT) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_en   = ctrl.exmem_en;
  assign halted     = (state_q == HALT);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, usesRt_id, dREN_ex, RegWr_ex, RegWr_mem;
  logic        dmemReq_mem, jumpFlush_ex, halt_ex, halt_mem;
  logic [4:0]  Rs_id, Rt_id, wsel_ex, wsel_mem;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted;
  logic [31:0] stall_cnt;
  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_halted;
  logic [2:0]  s_stall_cnt;

  always #5 CLK = ~CLK;

  id_ex_hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .usesRt_id(usesRt_id), .dREN_ex(dREN_ex), .RegWr_ex(RegWr_ex), .wsel_ex(wsel_ex),
    .RegWr_mem(RegWr_mem), .wsel_mem(wsel_mem), .dmemReq_mem(dmemReq_mem),
    .jumpFlush_ex(jumpFlush_ex), .halt_ex(halt_ex), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .halted(halted), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise saturation.
  id_ex_hazard_ctrl #(.CNT_W(3)) u_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .usesRt_id(usesRt_id), .dREN_ex(dREN_ex), .RegWr_ex(RegWr_ex), .wsel_ex(wsel_ex),
    .RegWr_mem(RegWr_mem), .wsel_mem(wsel_mem), .dmemReq_mem(dmemReq_mem),
    .jumpFlush_ex(jumpFlush_ex), .halt_ex(halt_ex), .halt_mem(halt_mem),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  // Control word order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted}
  localparam logic [6:0] E_RUN    = 7'b1101010;
  localparam logic [6:0] E_STALL  = 7'b0001110;
  localparam logic [6:0] E_FLUSH  = 7'b1111110;
  localparam logic [6:0] E_HALTEX = 7'b0111110;
  localparam logic [6:0] E_ZERO   = 7'b0000000;
  localparam logic [6:0] E_HALTED = 7'b0000001;
`ifdef HAZ_FWD_EN
  localparam logic [6:0] E_RAW    = E_RUN;
`else
  localparam logic [6:0] E_RAW    = E_STALL;
`endif

  typedef struct packed {
    logic       rst, ihit, dhit;
    logic [4:0] rs, rt;
    logic       urt, dren, rwe;
    logic [4:0] wse;
    logic       rwm;
    logic [4:0] wsm;
    logic       dreq, jmp, hex, hmem;
    logic [6:0] exp;
  } vec_t;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int unsigned cnt_m = 0;
  int          nchecks = 0;
  int          nfail = 0;
  int          row = 0;

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    v.ihit = 1'b1;
    v.exp  = E_RUN;
    return v;
  endfunction

  task automatic check();
    exp_t       e;
    logic [6:0] act;
    nchecks++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL scoreboard_empty row=%0d actual=0 entries required=1", row);
      return;
    end
    e   = sb.pop_front();
    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted};
    if (act !== e.ctl) begin
      nfail++;
      $display("FAIL ctl row=%0d actual=%b required=%b", row, act, e.ctl);
    end
    nchecks++;
    if (stall_cnt !== e.cnt) begin
      nfail++;
      $display("FAIL stall_cnt row=%0d actual=%0d required=%0d", row, stall_cnt, e.cnt);
    end
    nchecks++;
    if (s_stall_cnt !== e.sat) begin
      nfail++;
      $display("FAIL sat_cnt row=%0d actual=%0d required=%0d", row, s_stall_cnt, e.sat);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; Rs_id = v.rs; Rt_id = v.rt;
    usesRt_id = v.urt; dREN_ex = v.dren; RegWr_ex = v.rwe; wsel_ex = v.wse;
    RegWr_mem = v.rwm; wsel_mem = v.wsm; dmemReq_mem = v.dreq;
    jumpFlush_ex = v.jmp; halt_ex = v.hex; halt_mem = v.hmem;
    e.ctl = v.exp;
    e.cnt = cnt_m;
    e.sat = (cnt_m > 7) ? 3'd7 : 3'(cnt_m);
    sb.push_back(e);
    @(negedge CLK);
    check();
    @(posedge CLK);
    #1;
    if (v.rst) cnt_m = 0;
    else if (!v.exp[6] && !v.exp[0]) cnt_m++;
    row++;
  endtask

  initial begin
    vec_t v;
    // reset, then idle run
    v = idle(); v.rst = 1'b1; v.exp = E_ZERO; tbl.push_back(v); tbl.push_back(v);
    v = idle(); tbl.push_back(v);
    // load-use on Rs: one bubble
    v = idle(); v.dren = 1; v.rwe = 1; v.wse = 5'd5; v.rs = 5'd5; v.exp = E_STALL; tbl.push_back(v);
    v = idle(); tbl.push_back(v);
    // load to $0 never stalls
    v = idle(); v.dren = 1; v.rwe = 1; v.wse = 5'd0; v.rs = 5'd0; tbl.push_back(v);
    // MEM writer matches Rt but Rt unused
    v = idle(); v.rs = 5'd3; v.rt = 5'd8; v.rwm = 1; v.wsm = 5'd8; tbl.push_back(v);
    // MEM writer matches used Rt
    v.urt = 1; v.exp = E_RAW; tbl.push_back(v);
    // non-load EX writer matches Rs
    v = idle(); v.rwe = 1; v.wse = 5'd7; v.rs = 5'd7; v.exp = E_RAW; tbl.push_back(v);
    // MEM write to $0
    v = idle(); v.rwm = 1; v.wsm = 5'd0; v.rs = 5'd0; tbl.push_back(v);
    // fetch miss
    v = idle(); v.ihit = 0; v.exp = E_STALL; tbl.push_back(v);
    // jump flush beats load-use
    v = idle(); v.jmp = 1; v.dren = 1; v.rwe = 1; v.wse = 5'd5; v.rs = 5'd5; v.exp = E_FLUSH; tbl.push_back(v);
    // halt in EX
    v = idle(); v.hex = 1; v.exp = E_HALTEX; tbl.push_back(v);
    // data access hitting same cycle
    v = idle(); v.dreq = 1; v.dhit = 1; tbl.push_back(v);

    foreach (tbl[i]) step(tbl[i]);

    // data miss: 3 dead cycles, then dhit releases
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.dreq = 1; v.exp = E_ZERO; step(v);
    end
    v = idle(); v.dreq = 1; v.dhit = 1; step(v);
    v = idle(); step(v);

    // data miss then dhit cycle with load-use pending: bubble, no miss re-check
    v = idle(); v.dreq = 1; v.exp = E_ZERO; step(v);
    v = idle(); v.dreq = 1; v.dhit = 1; v.dren = 1; v.rwe = 1; v.wse = 5'd9; v.rs = 5'd9;
    v.exp = E_STALL; step(v);
    v = idle(); step(v);

    // halt in MEM: sticky HALT through 10 cycles of activity
    v = idle(); v.hmem = 1; v.exp = E_ZERO; step(v);
    for (int i = 0; i < 10; i++) begin
      v = idle(); v.jmp = (i % 2 == 0); v.ihit = (i % 3 != 0); v.exp = E_HALTED; step(v);
    end
    // reset out of HALT
    v = idle(); v.rst = 1; v.exp = E_HALTED; step(v);
    v = idle(); step(v);

    // long fetch stall: narrow counter saturates, wide one keeps counting
    for (int i = 0; i < 10; i++) begin
      v = idle(); v.ihit = 0; v.exp = E_STALL; step(v);
    end
    v = idle(); step(v);
    v = idle(); v.rst = 1; v.exp = E_ZERO; step(v);
    v = idle(); step(v);

    if (sb.size() != 0) begin
      nchecks++;
      nfail++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
